// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: synchronizes the line, qualifies the start bit at mid-bit,
// sequences data/parity/stop sampling on an oversampling tick and buffers one word.
module uart_rx_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  rx_clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  sample_tick,
  output logic                  shift,
  output logic                  parity_load,
  output logic                  check_stop,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned OSW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);

  localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic           ODD_BIT  = (PARITY_ODD != 0);
  localparam logic           HAS_PAR  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              sync_q;
  logic                    rxs;
  logic [OSW-1:0]          os_q, os_d;
  logic [BCW-1:0]          bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    perr_q, perr_d;
  logic                    shift_q, shift_d;
  logic                    pload_q, pload_d;
  logic                    cstop_q, cstop_d;
  logic                    ovr_q, ovr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    pe_q, pe_d;
  logic                    fe_q, fe_d;

  assign rxs = sync_q[1];

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    shift_d = 1'b0;
    pload_d = 1'b0;
    cstop_d = 1'b0;
    ovr_d   = 1'b0;
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    valid_d = valid_q;

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (sample_tick && !rxs) begin
          state_d = S_START;
          os_d    = '0;
        end
      end

      S_START: begin
        if (sample_tick) begin
          if (os_q == OS_HALF) begin
            os_d  = '0;
            bit_d = '0;
            if (rxs) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              perr_d  = 1'b0;
            end
          end else begin
            os_d = os_q + OSW'(1);
          end
        end
      end

      S_DATA: begin
        if (sample_tick) begin
          if (os_q == OS_LAST) begin
            shreg_d = {rxs, shreg_q[DATA_WIDTH-1:1]};
            shift_d = 1'b1;
            os_d    = '0;
            bit_d   = bit_q + BCW'(1);
            if (bit_q == BIT_LAST) begin
              state_d = HAS_PAR ? S_PARITY : S_STOP;
            end
          end else begin
            os_d = os_q + OSW'(1);
          end
        end
      end

      S_PARITY: begin
        if (sample_tick) begin
          if (os_q == OS_LAST) begin
            pload_d = 1'b1;
            perr_d  = ((^shreg_q) ^ rxs) != ODD_BIT;
            os_d    = '0;
            state_d = S_STOP;
          end else begin
            os_d = os_q + OSW'(1);
          end
        end
      end

      S_STOP: begin
        if (sample_tick) begin
          if (os_q == OS_LAST) begin
            cstop_d = 1'b1;
            os_d    = '0;
            bit_d   = '0;
            state_d = S_IDLE;
            // A consumer accepting the old word on this very edge frees the slot.
            if (!valid_q || rx_ready) begin
              data_d  = shreg_q;
              pe_d    = perr_q;
              fe_d    = ~rxs;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            os_d = os_q + OSW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        os_d    = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync_q  <= '1;
      os_q    <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      shift_q <= 1'b0;
      pload_q <= 1'b0;
      cstop_q <= 1'b0;
      ovr_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx_in};
      os_q    <= os_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      shift_q <= shift_d;
      pload_q <= pload_d;
      cstop_q <= cstop_d;
      ovr_q   <= ovr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  assign shift        = shift_q;
  assign parity_load  = pload_q;
  assign check_stop   = cstop_q;
  assign overrun      = ovr_q;
  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign parity_error = pe_q;
  assign frame_error  = fe_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_sequencer.md
# uart_rx_sequencer

Oversampling receive controller for the UART receive path. Synchronizes the serial line, qualifies the start bit at mid-bit, and sequences data, parity and stop sampling on a 16x baud enable. Drives the `shift`/`parity_load`/`check_stop` strobes to the receive datapath. Presents each completed frame through a one-entry output buffer with a valid/ready handshake and parity, frame and overrun status.

## Interface
Parameters:
- `DATA_WIDTH`, 8: data bits per frame, sent LSB first.
- `OVERSAMPLE`, 16: `sample_tick` pulses per bit period. Must be even and ≥4.
- `PARITY_EN`, 1: 1 = frame carries a parity bit.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity.

Ports:
- `rx_clk`  in  1  single clock for the whole block.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_in`  in  1  raw serial line, asynchronous; idles high.
- `sample_tick`  in  1  one-cycle enable at OVERSAMPLE × baud.
- `shift`  out  1  one-cycle strobe at each data-bit sample.
- `parity_load`  out  1  one-cycle strobe at the parity-bit sample.
- `check_stop`  out  1  one-cycle strobe at the stop-bit sample.
- `rx_data`  out  DATA_WIDTH  buffered received word.
- `rx_valid`  out  1  `rx_data` and its status flags are valid.
- `rx_ready`  in  1  consumer accepts the buffered word.
- `parity_error`  out  1  parity mismatch for the buffered word; qualified by `rx_valid`.
- `frame_error`  out  1  stop bit sampled low for the buffered word; qualified by `rx_valid`.
- `overrun`  out  1  one-cycle pulse when a completed frame is dropped.
- `busy`  out  1  state ≠ IDLE.

## Operation
- **Line synchronizer:** `rx_in` passes through a 2-FF synchronizer; the block uses only the synchronized value `rxs`. Both flops reset to 1.
- **Counters:**
  - `os_cnt` is clog2(OVERSAMPLE) bits and advances only on `sample_tick`.
  - `bit_cnt` is clog2(DATA_WIDTH+1) bits.
- **IDLE:** on `sample_tick` with `rxs`=0, go to START with `os_cnt`=0.
- **START:** on each tick, `os_cnt`++. At the tick where `os_cnt` = OVERSAMPLE/2−1 (mid start bit):
  - `rxs`=1: treat as a glitch and return to IDLE. No strobe, no status.
  - `rxs`=0: go to DATA with `os_cnt`=0 and `bit_cnt`=0.
- **DATA:** on each tick, `os_cnt`++. At the tick where `os_cnt` = OVERSAMPLE−1 (mid-bit):
  - Sample `rxs` into shift register bit DATA_WIDTH−1, shifting right, so the first bit received ends up as LSB.
  - Pulse `shift`, set `os_cnt`=0, `bit_cnt`++.
  - When `bit_cnt` reaches DATA_WIDTH, go to PARITY if PARITY_EN, else STOP.
- **PARITY:** at the mid-bit tick, pulse `parity_load` and latch `perr` = XOR(data bits, `rxs`) ≠ PARITY_ODD. Then go to STOP with `os_cnt`=0.
- **STOP:** at the mid-bit tick:
  - Pulse `check_stop` and set `ferr` = ~`rxs`.
  - Complete the frame (see output buffer) and return to IDLE.
  - IDLE may detect the next start from the following tick onward.
- **Frame errors:** parity and frame errors do not abort the frame. The word is still delivered with its flags set.
- **Output buffer:**
  - On completion, if `rx_valid`=0, or `rx_valid`=1 and `rx_ready`=1 in the same cycle: load `rx_data`, `parity_error`, `frame_error` and set `rx_valid`=1.
  - Otherwise keep the old word, drop the new one, and pulse `overrun`.
  - `rx_valid` clears on a cycle with `rx_valid` & `rx_ready` and no simultaneous completion.
  - `rx_data` and the flags are stable while `rx_valid`=1 and not accepted.
- **Reset** (asserted at any time, including mid-frame):
  - State goes to IDLE and both counters to 0; the partial frame is discarded.
  - All outputs go to 0, except the internal sync flops, which go to 1.
  - After release, a frame already in progress on the line is resynchronized only at the next high→low edge.

## Timing
- Sync latency: 2 `rx_clk` cycles from `rx_in` to `rxs`.
- All strobes (`shift`, `parity_load`, `check_stop`) are registered. Each asserts in the cycle after its qualifying `sample_tick` and lasts exactly 1 cycle.
- `rx_valid` rises in the same cycle as `check_stop`.
- `overrun` pulses in the same cycle as the dropped frame's `check_stop`.
- Strobe count per frame: exactly DATA_WIDTH `shift`, PARITY_EN `parity_load`, 1 `check_stop`.
- Ticks from the first low tick in IDLE to `check_stop`: OVERSAMPLE/2 + (DATA_WIDTH + PARITY_EN + 1) × OVERSAMPLE.
- `sample_tick` held high continuously is legal; every cycle is then a tick.

## Test plan
- **Clean frame:** DATA_WIDTH=8, even parity, send 0xA5 with parity 0 and stop 1 → 8 `shift`, 1 `parity_load`, 1 `check_stop`; `rx_data`=0xA5, `rx_valid`=1, both errors 0; `rx_ready`=1 for one cycle clears `rx_valid`.
- **Parity error:** send 0x01 with parity bit 0 → `rx_data`=0x01, `parity_error`=1, `frame_error`=0.
- **Frame error:** send 0x3C with stop bit low → `frame_error`=1, word still delivered; next frame 0x3C with valid stop → `frame_error`=0.
- **Glitch:** low pulse of 5 ticks on an idle line (OVERSAMPLE=16) → returns to IDLE, no strobes, `rx_valid` stays 0, `busy` high for ≤8 ticks.
- **Overrun:**
  - Two back-to-back frames 0x11 then 0x22 with `rx_ready`=0 → `overrun` pulses once, `rx_data` stays 0x11.
  - Repeat with `rx_ready`=1 in the second `check_stop` cycle → `rx_data`=0x22, no overrun.
- **Reset mid-frame:** assert `rst` after the 4th `shift` → all outputs 0 immediately and `busy`=0; after release, frame 0x7E is received correctly.
